// File: rtl/dither_quantizer.sv
`default_nettype none
// =============================================================================
// Module   : dither_quantizer
// Summary  : Streaming IN_WIDTH->OUT_WIDTH requantiser (truncate, 4x4 Bayer,
//            Floyd-Steinberg error diffusion) with a fixed 2-cycle latency.
// Revision : 1.0
// =============================================================================
module dither_quantizer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 1,
  parameter int H_ACTIVE  = 320,
  parameter int HC_WIDTH  = 11,
  parameter int VC_WIDTH  = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [1:0]           mode_in,
  input  logic [HC_WIDTH-1:0]  hcount_in,
  input  logic [VC_WIDTH-1:0]  vcount_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_valid_in,
  output logic [OUT_WIDTH-1:0] pixel_out,
  output logic [HC_WIDTH-1:0]  hcount_out,
  output logic [VC_WIDTH-1:0]  vcount_out,
  output logic                 data_valid_out
);

  localparam int EW    = IN_WIDTH + 2;
  localparam int SHIFT = IN_WIDTH - OUT_WIDTH;
  localparam int STEP  = 1 << SHIFT;
  localparam int MAXV  = (1 << IN_WIDTH) - 1;
  localparam int DEPTH = 2 * H_ACTIVE;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [1:0]          MODE_BAYER = 2'd2;
  localparam logic [1:0]          MODE_FS    = 2'd3;
  localparam logic [HC_WIDTH-1:0] NUM_COL    = HC_WIDTH'(H_ACTIVE);
  localparam logic [HC_WIDTH-1:0] LAST_COL   = HC_WIDTH'(H_ACTIVE - 1);

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: bayer = 4'd0;   4'h1: bayer = 4'd8;   4'h2: bayer = 4'd2;   4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;  4'h5: bayer = 4'd4;   4'h6: bayer = 4'd14;  4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;   4'h9: bayer = 4'd11;  4'ha: bayer = 4'd1;   4'hb: bayer = 4'd9;
      4'hc: bayer = 4'd15;  4'hd: bayer = 4'd7;   4'he: bayer = 4'd13;  default: bayer = 4'd5;
    endcase
  endfunction

  function automatic logic [AW-1:0] buf_addr(input logic bank, input logic [HC_WIDTH-1:0] col);
    buf_addr = (bank ? AW'(H_ACTIVE) : '0) + AW'(col);
  endfunction

  // ---------------- stage 0: mode latch, line-buffer read ----------------
  logic [1:0]    active_mode;
  logic          frame_start;
  logic [1:0]    pix_mode;
  logic [AW-1:0] rd_addr;

  always_comb begin
    frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    pix_mode    = frame_start ? mode_in : active_mode;
    rd_addr     = '0;
    if (hcount_in < NUM_COL) rd_addr = buf_addr(vcount_in[0], hcount_in);
  end

  logic                s1_valid;
  logic [1:0]          s1_mode;
  logic                s1_row0;
  logic [IN_WIDTH-1:0] s1_data;
  logic [HC_WIDTH-1:0] s1_h;
  logic [VC_WIDTH-1:0] s1_v;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_mode <= '0;
      s1_valid    <= 1'b0;
      s1_mode     <= '0;
      s1_row0     <= 1'b0;
      s1_data     <= '0;
      s1_h        <= '0;
      s1_v        <= '0;
    end else begin
      if (frame_start) active_mode <= mode_in;
      s1_valid <= data_valid_in;
      s1_mode  <= pix_mode;
      s1_row0  <= (vcount_in == '0);
      s1_data  <= data_in;
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
    end
  end

  // Two banks of below-errors: row parity picks the bank being read.
  logic signed [EW-1:0] ebuf [DEPTH];
  logic signed [EW-1:0] rd_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [EW-1:0] wr_data;

  always_ff @(posedge clk_in) begin
    if (wr_en) ebuf[wr_addr] <= wr_data;
    rd_data <= ebuf[rd_addr];
  end

  // ---------------- stage 1: quantise and diffuse ----------------
  logic signed [EW-1:0] e_right, carry_a, carry_b, pend_data;
  logic                 pend_valid;
  logic [AW-1:0]        pend_addr;

  logic                 fs_act, first_col;
  logic signed [EW-1:0] er_use, below_use, cb_use, err;
  logic signed [EW-1:0] sh7, sh5, sh3, sh1;
  logic [AW-1:0]        wr_base;
  int                   acc_i;
  logic [IN_WIDTH-1:0]  acc, recon;
  logic [OUT_WIDTH-1:0] q;

  always_comb begin
    fs_act    = (s1_mode == MODE_FS) && (s1_h < NUM_COL);
    first_col = (s1_h == '0);
    er_use    = first_col ? '0 : e_right;
    below_use = s1_row0 ? '0 : rd_data;
    cb_use    = first_col ? '0 : carry_b;
    wr_base   = buf_addr(~s1_v[0], '0);

    if (s1_mode == MODE_BAYER)
      acc_i = int'(s1_data) + (int'(bayer(s1_v[1:0], s1_h[1:0])) * STEP) / 16 - STEP / 2;
    else if (fs_act)
      acc_i = int'(s1_data) + int'(er_use) + int'(below_use);
    else
      acc_i = int'(s1_data);
    if (acc_i < 0)    acc_i = 0;
    if (acc_i > MAXV) acc_i = MAXV;
    acc = IN_WIDTH'(acc_i);
    q   = acc[IN_WIDTH-1 -: OUT_WIDTH];

    recon = '0;
    for (int i = 0; i < IN_WIDTH; i++) recon[IN_WIDTH-1-i] = q[OUT_WIDTH-1-(i % OUT_WIDTH)];

    err = EW'(int'(acc) - int'(recon));
    sh7 = EW'((int'(err) * 7) >>> 4);
    sh5 = EW'((int'(err) * 5) >>> 4);
    sh3 = EW'((int'(err) * 3) >>> 4);
    sh1 = EW'(int'(err) >>> 4);

    // The deferred last-column write lands while the next line starts at column 0,
    // which never writes, so the single port is free.
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (pend_valid) begin
      wr_en   = 1'b1;
      wr_addr = pend_addr;
      wr_data = pend_data;
    end else if (s1_valid && fs_act && !first_col) begin
      wr_en   = 1'b1;
      wr_addr = wr_base + AW'(s1_h - HC_WIDTH'(1));
      wr_data = carry_a + sh3;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      e_right    <= '0;
      carry_a    <= '0;
      carry_b    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= 1'b0;
      if (s1_valid && fs_act) begin
        e_right <= sh7;
        carry_a <= cb_use + sh5;
        carry_b <= sh1;
        if (s1_h == LAST_COL) begin
          pend_valid <= 1'b1;
          pend_addr  <= wr_base + AW'(H_ACTIVE - 1);
          pend_data  <= cb_use + sh5;
        end
      end
    end
  end

  // ---------------- stage 2: output registers ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_out      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      if (s1_valid) pixel_out <= q;
      hcount_out     <= s1_h;
      vcount_out     <= s1_v;
      data_valid_out <= s1_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dither_quantizer.sv
`default_nettype none
// =============================================================================
// Module   : tb_dither_quantizer
// Summary  : Self-checking bench; two DUTs (1-bit and 2-bit output) share stimulus.
// Revision : 1.0
// =============================================================================
module tb_dither_quantizer;

  localparam int HA = 10;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [1:0]  mode_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [7:0]  data_in;
  logic        data_valid_in;

  logic [0:0]  pix1;
  logic [1:0]  pix2;
  logic [10:0] hc1, hc2;
  logic [9:0]  vc1, vc2;
  logic        dv1, dv2;

  dither_quantizer #(.IN_WIDTH(8), .OUT_WIDTH(1), .H_ACTIVE(HA), .HC_WIDTH(11), .VC_WIDTH(10)) u_dut1 (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_in(data_in), .data_valid_in(data_valid_in),
    .pixel_out(pix1), .hcount_out(hc1), .vcount_out(vc1), .data_valid_out(dv1));

  dither_quantizer #(.IN_WIDTH(8), .OUT_WIDTH(2), .H_ACTIVE(HA), .HC_WIDTH(11), .VC_WIDTH(10)) u_dut2 (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_in(data_in), .data_valid_in(data_valid_in),
    .pixel_out(pix2), .hcount_out(hc2), .vcount_out(vc2), .data_valid_out(dv2));

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   h;
    int   vc;
    int   p1;
    int   p2;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_mode = 0;
  int last_p[2];
  int dif  [0:1][0:31][0:15];
  int cap  [0:1][0:31][0:15];
  int saved[0:1][0:31][0:15];
  int bayer_t[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int fdiv16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  // Reference: textbook raster diffusion over a whole-frame error array.
  function automatic int model_pix(input int w, input int ow, input int h, input int vc, input int d);
    int  stp, acc, q, r, e;
    bit  fs;
    stp = 1 << (8 - ow);
    fs  = (m_mode == 3) && (h < HA);
    if (m_mode == 2)  acc = d + (bayer_t[vc % 4][h % 4] * stp) / 16 - stp / 2;
    else if (fs)      acc = d + dif[w][vc][h];
    else              acc = d;
    if (acc < 0)   acc = 0;
    if (acc > 255) acc = 255;
    q = acc / stp;
    if (fs) begin
      r = q * 255 / ((1 << ow) - 1);
      e = acc - r;
      if (h + 1 < HA) dif[w][vc][h+1]   += fdiv16(e * 7);
      if (h > 0)      dif[w][vc+1][h-1] += fdiv16(e * 3);
      dif[w][vc+1][h] += fdiv16(e * 5);
      if (h + 1 < HA) dif[w][vc+1][h+1] += fdiv16(e);
    end
    return q;
  endfunction

  task automatic step(input logic r, input logic vld, input int md, input int h, input int vc, input int d);
    @(posedge clk);
    #1;
    rst_in        = r;
    data_valid_in = vld;
    mode_in       = 2'(md);
    hcount_in     = 11'(h);
    vcount_in     = 10'(vc);
    data_in       = 8'(d);
    if (!r) begin
      foreach (exp_q[i]) exp_q[i] = '{1'b0, 0, 0, 0, 0};
      exp_q.push_back('{1'b0, 0, 0, 0, 0});
      m_mode = 0;
      last_p[0] = 0;
      last_p[1] = 0;
      #1;
      check("rst pixel1", int'(pix1), 0);
      check("rst pixel2", int'(pix2), 0);
      check("rst hcount", int'(hc1) + int'(hc2), 0);
      check("rst vcount", int'(vc1) + int'(vc2), 0);
      check("rst valid",  int'(dv1) + int'(dv2), 0);
    end else begin
      if (vld) begin
        if (h == 0 && vc == 0) begin
          m_mode = md;
          foreach (dif[a, b, c]) dif[a][b][c] = 0;
        end
        last_p[0] = model_pix(0, 1, h, vc, d);
        last_p[1] = model_pix(1, 2, h, vc, d);
      end
      exp_q.push_back('{vld, h, vc, last_p[0], last_p[1]});
    end
  endtask

  // kind: 0 constant, 1 ramp, 2 random; gap: 0 none, 1 3-on/3-off, 2 random
  task automatic frame(input int w, input int hgt, input int kind, input int cval,
                       input int md, input int gap, input int mid_md);
    int d, cnt, cur;
    cnt = 0;
    for (int vc = 0; vc < hgt; vc++) begin
      for (int h = 0; h < w; h++) begin
        cur = (vc >= hgt / 2) ? mid_md : md;
        if (gap == 1) begin
          while ((cnt % 6) >= 3) begin
            step(1'b1, 1'b0, cur, h, vc, $urandom_range(0, 255));
            cnt++;
          end
        end else if (gap == 2) begin
          while ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, cur, h, vc, $urandom_range(0, 255));
        end
        if (kind == 0)      d = cval;
        else if (kind == 1) d = (vc * w + h) % 256;
        else                d = $urandom_range(0, 255);
        step(1'b1, 1'b1, cur, h, vc, d);
        cnt++;
      end
    end
    repeat (4) step(1'b1, 1'b0, md, 0, 0, 0);
  endtask

  // One compare process: DUT outputs at each negedge belong to the input two cycles back.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() == 3) begin
        ce = exp_q.pop_front();
        check("valid_out d1",  int'(dv1), int'(ce.v));
        check("valid_out d2",  int'(dv2), int'(ce.v));
        check("hcount_out d1", int'(hc1), ce.h);
        check("hcount_out d2", int'(hc2), ce.h);
        check("vcount_out d1", int'(vc1), ce.vc);
        check("vcount_out d2", int'(vc2), ce.vc);
        check("pixel_out d1",  int'(pix1), ce.p1);
        check("pixel_out d2",  int'(pix2), ce.p2);
        if (dv1 && vc1 < 32 && hc1 < 16) cap[0][vc1][hc1] = int'(pix1);
        if (dv2 && vc2 < 32 && hc2 < 16) cap[1][vc2][hc2] = int'(pix2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int count_val(input int w, input int rows, input int cols, input int val);
    int n = 0;
    for (int v = 0; v < rows; v++)
      for (int h = 0; h < cols; h++)
        if (cap[w][v][h] == val) n++;
    return n;
  endfunction

  function automatic int diff_saved(input int rows, input int cols);
    int n = 0;
    for (int w = 0; w < 2; w++)
      for (int v = 0; v < rows; v++)
        for (int h = 0; h < cols; h++)
          if (cap[w][v][h] != saved[w][v][h]) n++;
    return n;
  endfunction

  task automatic clear_cap();
    foreach (cap[a, b, c]) cap[a][b][c] = -1;
  endtask

  task automatic save_cap();
    foreach (cap[a, b, c]) saved[a][b][c] = cap[a][b][c];
  endtask

  initial begin
    int hi1, lo1, hi2, lo2, ones, md, w;
    rst_in = 1'b0; mode_in = '0; hcount_in = '0; vcount_in = '0; data_in = '0; data_valid_in = 1'b0;
    repeat (4) step(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (2) step(1'b1, 1'b0, 0, 0, 0, 0);

    // Truncate, constant 0xBC, two frames
    for (int k = 0; k < 2; k++) begin
      clear_cap();
      frame(10, 10, 0, 8'hBC, 0, 0, 0);
      check("trunc ones d1", count_val(0, 10, 10, 1), 100);
      check("trunc q2 d2",   count_val(1, 10, 10, 2), 100);
    end

    // Bayer, constant 0x80, 8x8
    clear_cap();
    frame(8, 8, 0, 8'h80, 2, 0, 2);
    hi1 = 0; lo1 = 0; hi2 = 0; lo2 = 0;
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < 8; h++) begin
        if (bayer_t[v % 4][h % 4] >= 8) begin
          if (cap[0][v][h] == 1) hi1++;
          if (cap[1][v][h] == 2) hi2++;
        end else begin
          if (cap[0][v][h] == 1) lo1++;
          if (cap[1][v][h] == 1) lo2++;
        end
      end
    check("bayer ones at B>=8", hi1, 32);
    check("bayer ones at B<8",  lo1, 0);
    check("bayer2 q2 at B>=8",  hi2, 32);
    check("bayer2 q1 at B<8",   lo2, 32);

    // Floyd-Steinberg, constant 0x80
    clear_cap();
    frame(10, 10, 0, 8'h80, 3, 0, 3);
    check("fs first pixel", cap[0][0][0], 1);
    ones = count_val(0, 10, 10, 1);
    check("fs ones within 45..55", int'(ones >= 45 && ones <= 55), 1);
    save_cap();

    // Same frame with 3-on/3-off valid gaps and a mid-frame mode change
    clear_cap();
    frame(10, 10, 0, 8'h80, 3, 1, 0);
    check("gapped vs gap-free diffs", diff_saved(10, 10), 0);

    // Ramp, two frames: second frame must equal the first
    clear_cap();
    frame(10, 10, 1, 0, 3, 0, 3);
    save_cap();
    clear_cap();
    frame(10, 10, 1, 0, 3, 0, 3);
    check("ramp repeat diffs", diff_saved(10, 10), 0);

    // Reset in the middle of a diffusion frame, then a fresh frame
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < 10; h++) step(1'b1, 1'b1, 3, h, v, $urandom_range(0, 255));
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3, k, 3, $urandom_range(0, 255));
    repeat (2) step(1'b1, 1'b0, 0, 0, 0, 0);
    frame(10, 10, 2, 0, 3, 0, 3);

    // Randomised frames: mode, width (incl. columns past H_ACTIVE), height, gaps
    for (int k = 0; k < 8; k++) begin
      md = (k % 2 == 1) ? 3 : int'($urandom_range(0, 3));
      w  = ($urandom_range(0, 1) == 1) ? 12 : 10;
      frame(w, int'($urandom_range(4, 10)), 2, 0, md, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
